// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_BYTES = 4;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // A request faults if it is not word aligned or falls outside the word array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] above;
    above = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (above != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with byte-enable writes and a registered read port.
// The read register doubles as the response data register, so it can be cleared.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic                 rd_en_i,
  input  logic                 clr_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [NUM_BYTES-1:0] be_i,
  output logic [DATA_W-1:0]    rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Storage is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < int'(NUM_BYTES); i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (clr_i) begin
      rdata_d = '0;
    end else if (rd_en_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one request at a time, fixed access latency, held response.
// Optional macro DMEM_ACCEPT_ON_RESP_EN lets a new request be taken on the response handshake.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [NUM_BYTES-1:0] req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [NUM_BYTES-1:0] be_q, be_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;

  logic accept;
  logic access_err;
  logic arr_we, arr_rd, arr_clr;

  always_comb begin
`ifdef DMEM_ACCEPT_ON_RESP_EN
    req_ready = (state_q == StIdle) || ((state_q == StResp) && rsp_ready);
`else
    req_ready = (state_q == StIdle);
`endif
  end

  assign accept     = req_valid && req_ready;
  assign access_err = addr_err(addr_q, ADDR_W);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    arr_we      = 1'b0;
    arr_rd      = 1'b0;
    arr_clr     = 1'b0;

    // accept can only be high in states that are allowed to take a request
    if (accept) begin
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
      cnt_d   = CntInit;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = access_err;
          arr_we      = we_q && !access_err;
          arr_rd      = !we_q && !access_err;
          arr_clr     = we_q || access_err;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          arr_clr     = 1'b1;
          state_d     = accept ? StWait : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (arr_we),
    .rd_en_i (arr_rd),
    .clr_i   (arr_clr),
    .addr_i  (addr_q[ADDR_W+1:2]),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (rsp_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Randomised self-checking bench for dmem_resp against a word-map reference model.
module tb_dmem_resp;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned LATENCY = 2;
`ifdef DMEM_ACCEPT_ON_RESP_EN
  localparam int Gap = LATENCY + 1;
`else
  localparam int Gap = LATENCY + 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_m [int];

  dmem_resp #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] addr);
    logic [63:0] limit;
    logic [63:0] a;
    limit = 64'd1 << (ADDR_W + 2);
    a     = {32'd0, addr};
    return ((a % 4) != 0) || (a >= limit);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
    bit ok;
    ok        = 1'b0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      lat++;
      if (rsp_valid) break;
    end
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input string tag);
    bit          e;
    bit          known;
    logic [31:0] exp;
    int          lat;
    int          key;
    logic [31:0] w;
    e     = ref_err(addr);
    known = 1'b1;
    exp   = '0;
    key   = int'(addr >> 2);
    if (!we && !e) begin
      if (mem_m.exists(key)) exp = mem_m[key];
      else known = 1'b0;
    end
    send(we, addr, wdata, be);
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'(LATENCY));
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_err"}, 32'(rsp_err), 32'(e));
    if (known) check({tag, "_rdata"}, rsp_rdata, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_err"}, 32'(rsp_err), 32'(e));
      check({tag, "_hold_rready"}, 32'(req_ready), 32'd0);
      if (known) check({tag, "_hold_rdata"}, rsp_rdata, exp);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    if (we && !e && (be != 4'h0)) begin
      if (mem_m.exists(key) || be == 4'hF) begin
        w = mem_m.exists(key) ? mem_m[key] : 32'd0;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mem_m[key] = w;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    int          acc[$];
    logic [31:0] pool[8];
    logic [31:0] a;
    int          op;

    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10");
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, "ld10");
    do_req(1'b1, 32'h40, 32'h11223344, 4'hF, 0, "st40");
    do_req(1'b1, 32'h40, 32'h0000AA00, 4'b0010, 0, "st40_be");
    do_req(1'b0, 32'h40, 32'h0, 4'hF, 1, "ld40");

    do_req(1'b0, 32'h13, 32'h0, 4'hF, 0, "ld_misal");
    do_req(1'b0, 32'h1000, 32'h0, 4'hF, 0, "ld_range");
    do_req(1'b1, 32'h1010, 32'h0BADF00D, 4'hF, 0, "st_range");
    do_req(1'b1, 32'h12, 32'h0BADF00D, 4'hF, 0, "st_misal");
    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, "st_be0");
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, "ld10_again");
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 5, "ld40_hold");

    // Reset during WAIT of a store must drop it.
    do_req(1'b1, 32'h20, 32'h5, 4'hF, 0, "st20");
    send(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_wait");
    tick();
    rst_n = 1'b1;
    tick();
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 0, "ld20");

    // Reset while a load response is pending clears it asynchronously.
    send(1'b0, 32'h10, 32'h0, 4'hF);
    wait_rsp(lat);
    check("rst_resp_pre", rsp_rdata, mem_m[4]);
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_resp");
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      pool[i] = 32'((100 + i * 113) << 2);
      do_req(1'b1, pool[i], $urandom, 4'hF, 0, "pool_init");
    end
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      a  = pool[$urandom_range(0, 7)];
      if (op == 2) begin
        if ($urandom_range(0, 1) == 0) a = a | 32'($urandom_range(1, 3));
        else a = ($urandom | 32'h1000) & ~32'h3;
      end
      do_req((op == 1) || (op == 2 && $urandom_range(0, 1) == 1), a, $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 2), "rand");
    end

    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_be    = 4'hF;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (req_ready) acc.push_back(c);
      if (rsp_valid) check("b2b_rdata", rsp_rdata, mem_m[4]);
      tick();
    end
    req_valid = 1'b0;
    repeat (10) tick();
    rsp_ready = 1'b0;
    check("b2b_count", 32'(acc.size() >= 5), 32'd1);
    for (int i = 1; i < acc.size(); i++) check("b2b_gap", 32'(acc[i] - acc[i-1]), 32'(Gap));
    check("b2b_idle_valid", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
Data-memory responder for the single-cycle core's load/store port, which the processor drives as initiator. Accepts one load or store request over a valid/ready handshake. Waits a configurable number of cycles, accesses a word-organised array with byte enables, and returns read data over a second valid/ready handshake. Its response data feeds writeback's memory-data input.

Parameters:
ADDR_W, 10, word-address bits; the array holds 2^ADDR_W 32-bit words.
LATENCY, 2, cycles from request accept to array access; legal range is 1 to 15.

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock, asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  store byte enables; bit i covers bits [8i+7:8i]
rsp_valid  output  1  response present
rsp_ready  input  1  core can take the response
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_err  output  1  misaligned or out-of-range access

Behaviour:
- FSM states: IDLE, WAIT, RESP. On reset: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0. req_ready = (state == IDLE), so it reads 1 while and after reset.
- IDLE: on req_valid && req_ready, latch we/addr/wdata/be, load the counter with LATENCY-1, and go to WAIT.
- WAIT: decrement the counter. At counter == 0, perform the access on that edge and go to RESP.
  - Load: rsp_rdata <= array word.
  - Store: write enabled bytes; rsp_rdata <= 0.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready. On the handshake: rsp_valid <= 0, rsp_rdata <= 0, go to IDLE.
- Latency: a request accepted at edge N gives rsp_valid high after edge N+LATENCY. Throughput is one request per LATENCY+2 cycles when rsp_ready is held high.
- Error: addr[1:0] != 0, or any addr bit above ADDR_W+1 set, gives rsp_err = 1, no array access, and rsp_rdata = 0.
- Store with be = 4'b0000: no array change; response has err = 0.
- Loads ignore req_be and always return the full word.
- req_valid outside IDLE is ignored; the core must hold it, with stable fields, until accepted.
- Reset mid-operation: transaction dropped. A store still in WAIT before its access edge is not committed.
- Array contents are not reset and persist across rst_n.

Optional Feature:
Macro: DMEM_ACCEPT_ON_RESP_EN.
- Defined: in RESP, req_ready = rsp_ready. A request accepted on the response-handshake edge goes directly to WAIT with its own fields latched, giving one request per LATENCY+1 cycles.
- Undefined: req_ready is high only in IDLE, as specified above.

Decomposition:
- Package dmem_pkg holds:
  - state enum (IDLE/WAIT/RESP);
  - DATA_W = 32;
  - NUM_BYTES = 4;
  - alignment and range check function;
  - counter width constant (4 bits).
- Sub-module dmem_array holds the storage: synchronous write with byte enables and synchronous read, one port. FSM, counter and error logic stay in dmem_resp.

Test Plan:
- Store addr 0x10, wdata 0xDEADBEEF, be 4'hF; then load 0x10 -> rsp_rdata 0xDEADBEEF, err 0; rsp_valid rises exactly LATENCY cycles after each accept.
- Store 0x11223344 full word; then store be 4'b0010, wdata 0x0000AA00; load -> 0x1122AA44.
- Load addr 0x13 -> rsp_err 1, rdata 0. Load at byte address 2^(ADDR_W+2) -> rsp_err 1. Array is unchanged in both cases.
- rsp_ready held low 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready 0. Then raise rsp_ready -> IDLE next cycle.
- Assert rst_n low during WAIT of a store to 0x20 (prior value 0x5) -> outputs reset asynchronously; a later load of 0x20 returns 0x5.
- Back-to-back requests with rsp_ready = 1 -> accepts spaced LATENCY+2 cycles apart, or LATENCY+1 with DMEM_ACCEPT_ON_RESP_EN.
